// File: rtl/apb_master_arbiter_if.sv
// Bundle of requester-side and APB-side signals shared by apb_master_arbiter and its environment.
// The master modport is the arbiter's view; the slave modport is the view of whatever drives requests and the APB slave.
interface apb_master_arbiter_if #(
  parameter int NumOfRequesters = 2
);

  logic [NumOfRequesters-1:0]    req;
  logic [NumOfRequesters-1:0]    req_write;
  logic [16*NumOfRequesters-1:0] req_addr;
  logic [32*NumOfRequesters-1:0] req_wdata;
  logic [NumOfRequesters-1:0]    ack;
  logic [31:0]                   rdata;
  logic                          err;

  logic [15:0] PADDR;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic        PREADY;
  logic [31:0] PRDATA;
  logic        PSLVERROR;

  modport master (
    input  req, req_write, req_addr, req_wdata, PREADY, PRDATA, PSLVERROR,
    output ack, rdata, err, PADDR, PSEL, PENABLE, PWRITE, PWDATA
  );

  modport slave (
    output req, req_write, req_addr, req_wdata, PREADY, PRDATA, PSLVERROR,
    input  ack, rdata, err, PADDR, PSEL, PENABLE, PWRITE, PWDATA
  );

endinterface

// File: rtl/apb_master_arbiter.sv
// Round-robin arbiter that lets several requesters share one APB master port.
// Define APB_ARB_TIMEOUT_EN to bound the ACCESS phase to TimeoutCycles cycles.
module apb_master_arbiter #(
  parameter int NumOfRequesters = 2,
  parameter int TimeoutCycles   = 255
) (
  input logic                  PCLK,
  input logic                  PRESETn,
  apb_master_arbiter_if.master bus
);

  localparam int GW = $clog2(NumOfRequesters);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  if (NumOfRequesters < 2 || NumOfRequesters > 8 || TimeoutCycles < 1) begin : g_param_check
    $error("apb_master_arbiter: parameter out of range");
  end

  logic [1:0]                 state;
  logic [GW-1:0]              last_grant;
  logic [GW-1:0]              next_grant;
  logic [GW-1:0]              cand;
  logic                       found;
  int                         cand_sum;
  logic [15:0]                paddr_q;
  logic [31:0]                pwdata_q;
  logic                       pwrite_q;
  logic [31:0]                rdata_q;
  logic                       err_q;
  logic [NumOfRequesters-1:0] ack_vec;

  // Search starts one past the previous winner so every requester gets a turn.
  always_comb begin
    next_grant = last_grant;
    found      = 1'b0;
    cand       = '0;
    cand_sum   = 0;
    for (int off = 1; off <= NumOfRequesters; off++) begin
      cand_sum = int'(last_grant) + off;
      if (cand_sum >= NumOfRequesters) begin
        cand_sum = cand_sum - NumOfRequesters;
      end
      cand = GW'(cand_sum);
      if (!found && bus.req[cand]) begin
        found      = 1'b1;
        next_grant = cand;
      end
    end
  end

`ifdef APB_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TimeoutCycles + 1);

  logic [TW-1:0] access_cnt;
  logic          timeout_hit;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      access_cnt <= '0;
    end else if (state != ACCESS) begin
      access_cnt <= '0;
    end else begin
      access_cnt <= access_cnt + TW'(1);
    end
  end

  assign timeout_hit = (state == ACCESS) && (access_cnt == TW'(TimeoutCycles - 1));
`endif

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state      <= IDLE;
      last_grant <= GW'(NumOfRequesters - 1);
      paddr_q    <= '0;
      pwdata_q   <= '0;
      pwrite_q   <= 1'b0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            state      <= SETUP;
            last_grant <= next_grant;
            paddr_q    <= bus.req_addr[16*next_grant +: 16];
            pwdata_q   <= bus.req_wdata[32*next_grant +: 32];
            pwrite_q   <= bus.req_write[next_grant];
          end
        end
        SETUP: begin
          state <= ACCESS;
        end
        ACCESS: begin
          if (bus.PREADY) begin
            rdata_q <= bus.PRDATA;
            err_q   <= bus.PSLVERROR;
            state   <= DONE;
          end
`ifdef APB_ARB_TIMEOUT_EN
          else if (timeout_hit) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
            state   <= DONE;
          end
`endif
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // The completion pulse goes to the requester that owns the finished transfer.
  always_comb begin
    ack_vec = '0;
    if (state == DONE) begin
      ack_vec[last_grant] = 1'b1;
    end
  end

  assign bus.PSEL    = (state == SETUP) || (state == ACCESS);
  assign bus.PENABLE = (state == ACCESS);
  assign bus.PADDR   = paddr_q;
  assign bus.PWDATA  = pwdata_q;
  assign bus.PWRITE  = pwrite_q;
  assign bus.ack     = ack_vec;
  assign bus.rdata   = rdata_q;
  assign bus.err     = err_q;

endmodule
